// File: rtl/t03_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// delivery fault codes and the default substitute instruction.
package t03_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_TIMEOUT  = 2'b10
    } fault_e;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/t03_instr_fetch.sv
// Instruction fetch unit: issues one memory request per fetch, delivers the
// returned word or a NOP with a fault code on misalignment or ack timeout.
//
// state | meaning
// IDLE  | waiting for fetchEn; memAck ignored
// REQ   | memReq high on latched address, timeout counter running
// FAULT | one-cycle delivery of NOP_INSTR with a fault code
module t03_instr_fetch
    import t03_fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        fetchEn,
    input  logic [31:0] pcAddr,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic        freezePc,
    output logic [1:0]  fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  addr_q, addr_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [31:0]  instr_q, instr_d;
    logic         instr_valid_q, instr_valid_d;
    fault_e       fault_q, fault_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            addr_q        <= 32'd0;
            cnt_q         <= 8'd0;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fault_q       <= FLT_NONE;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        fault_d       = fault_q;

        case (state_q)
            IDLE: begin
                if (fetchEn) begin
                    if (pcAddr[1:0] == 2'b00) begin
                        addr_d  = pcAddr;
                        cnt_d   = 8'd0;
                        state_d = REQ;
                    end else begin
                        // Fault delivery is registered on entry so it is visible during FAULT.
                        fault_d       = FLT_MISALIGN;
                        instr_d       = NOP_INSTR;
                        instr_valid_d = 1'b1;
                        state_d       = FAULT;
                    end
                end
            end
            REQ: begin
                // An ack in the final allowed cycle takes priority over the timeout.
                if (memAck) begin
                    instr_d       = memRdata;
                    instr_valid_d = 1'b1;
                    fault_d       = FLT_NONE;
                    state_d       = IDLE;
                end else if (cnt_q == TIMEOUT - 8'd1) begin
                    fault_d       = FLT_TIMEOUT;
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b1;
                    state_d       = FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign memReq     = (state_q == REQ);
    assign memAddr    = memReq ? addr_q : 32'd0;
    assign freezePc   = (state_q != IDLE) || fetchEn;
    assign instr      = instr_q;
    assign instrValid = instr_valid_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_t03_instr_fetch.sv
// Self-checking bench for t03_instr_fetch: directed vector table, hand-written
// multi-cycle sequences and randomized fetches against a transaction-level model.
module tb_t03_instr_fetch;

    localparam int          TB_T = 4;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk;
    logic        nrst;
    logic        fetchEn;
    logic [31:0] pcAddr;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic [31:0] instr;
    logic        instrValid;
    logic        freezePc;
    logic [1:0]  fault;

    int checks = 0;
    int errors = 0;

    t03_instr_fetch #(.NOP_INSTR(NOP), .TIMEOUT(8'(TB_T))) dut (
        .clk        (clk),
        .nrst       (nrst),
        .fetchEn    (fetchEn),
        .pcAddr     (pcAddr),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memRdata   (memRdata),
        .instr      (instr),
        .instrValid (instrValid),
        .freezePc   (freezePc),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        int          delay;      // REQ cycle on which memAck is given; beyond TB_T means never
        logic [31:0] data;
        int          exp_req;
        logic [31:0] exp_instr;
        logic [1:0]  exp_fault;
        int          exp_freeze;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Outcome of one fetch from the rules: misaligned -> NOP/01 with no request,
    // ack within the window -> data/00, otherwise the full window then NOP/10.
    function automatic vec_t predict(input logic [31:0] a, input int d, input logic [31:0] dat);
        vec_t v;
        v.addr  = a;
        v.delay = d;
        v.data  = dat;
        if (a[1:0] != 2'b00) begin
            v.exp_req = 0;    v.exp_instr = NOP; v.exp_fault = 2'b01; v.exp_freeze = 2;
        end else if (d <= TB_T) begin
            v.exp_req = d;    v.exp_instr = dat; v.exp_fault = 2'b00; v.exp_freeze = 1 + d;
        end else begin
            v.exp_req = TB_T; v.exp_instr = NOP; v.exp_fault = 2'b10; v.exp_freeze = TB_T + 2;
        end
        return v;
    endfunction

    // Entered mid-cycle with the DUT in IDLE; leaves mid-cycle in IDLE with fetchEn=0.
    task automatic run_vec(input vec_t v, input string nm);
        int          req_cnt = 0;
        int          vcnt = 0;
        int          freeze_cnt = 0;
        int          addr_bad = 0;
        int          cyc = 0;
        int          after = 0;
        bit          seen = 0;
        logic [31:0] got_i = '0;
        logic [1:0]  got_f = '0;
        logic [31:0] hold_i = '0;
        logic [1:0]  hold_f = '0;
        pcAddr  = v.addr;
        fetchEn = 1'b1;
        memAck  = 1'b0;
        #1;
        if (freezePc) freeze_cnt++;
        while (cyc < 20 && after < 2) begin
            @(posedge clk);
            #1;
            fetchEn = 1'b0;
            memAck  = 1'b0;
            #1;
            cyc++;
            if (memReq) begin
                req_cnt++;
                if (memAddr !== v.addr) addr_bad++;
                memAck   = (req_cnt == v.delay);
                memRdata = memAck ? v.data : $urandom;
            end else if (memAddr !== 32'd0) begin
                addr_bad++;
            end
            if (freezePc) freeze_cnt++;
            if (instrValid) begin
                vcnt++;
                got_i = instr;
                got_f = fault;
            end
            if (seen) begin
                hold_i = instr;
                hold_f = fault;
                after++;
            end
            if (instrValid) seen = 1;
            if (seen && after == 0) after = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_delivery actual=none required=instrValid", nm);
        end else begin
            check({nm, "_req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
            check({nm, "_addr"}, 32'(addr_bad), 32'd0);
            check({nm, "_valid_pulses"}, 32'(vcnt), 32'd1);
            check({nm, "_instr"}, got_i, v.exp_instr);
            check({nm, "_fault"}, 32'(got_f), 32'(v.exp_fault));
            check({nm, "_freeze"}, 32'(freeze_cnt), 32'(v.exp_freeze));
            check({nm, "_instr_hold"}, hold_i, v.exp_instr);
            check({nm, "_fault_hold"}, 32'(hold_f), 32'(v.exp_fault));
        end
    endtask

    initial begin
        vec_t vecs[6];
        vec_t rv;
        int   cnt;
        logic [31:0] a;

        vecs[0] = '{32'h0000_0100, 3,  32'h0050_0093, 3, 32'h0050_0093, 2'b00, 4};
        vecs[1] = '{32'h0000_0102, 1,  32'h1234_5678, 0, NOP,           2'b01, 2};
        vecs[2] = '{32'h0000_0300, 99, 32'h5555_AAAA, 4, NOP,           2'b10, 6};
        vecs[3] = '{32'h0000_0304, 4,  32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 2'b00, 5};
        vecs[4] = '{32'h0000_0003, 2,  32'h0BAD_0BAD, 0, NOP,           2'b01, 2};
        vecs[5] = '{32'h0000_0008, 1,  32'hCAFE_F00D, 1, 32'hCAFE_F00D, 2'b00, 2};

        nrst     = 1'b0;
        fetchEn  = 1'b0;
        pcAddr   = 32'd0;
        memAck   = 1'b0;
        memRdata = 32'd0;
        #13;
        check("rst_memReq", 32'(memReq), 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_instrValid", 32'(instrValid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_freezePc", 32'(freezePc), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #2;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("dir%0d", i));

        // Back-to-back fetches with an immediate ack each, IDLE in between.
        pcAddr  = 32'h0;
        fetchEn = 1'b1;
        @(posedge clk); #2;
        check("b2b_req1", 32'(memReq), 32'd1);
        check("b2b_addr1", memAddr, 32'h0);
        memAck = 1'b1; memRdata = 32'h1111_2222;
        @(posedge clk); #1;
        memAck = 1'b0; pcAddr = 32'h4;
        #1;
        check("b2b_valid1", 32'(instrValid), 32'd1);
        check("b2b_instr1", instr, 32'h1111_2222);
        check("b2b_idle_between", 32'(memReq), 32'd0);
        check("b2b_freeze_idle", 32'(freezePc), 32'd1);
        @(posedge clk); #2;
        check("b2b_req2", 32'(memReq), 32'd1);
        check("b2b_addr2", memAddr, 32'h4);
        memAck = 1'b1; memRdata = 32'h3333_4444;
        @(posedge clk); #1;
        memAck = 1'b0; fetchEn = 1'b0;
        #1;
        check("b2b_valid2", 32'(instrValid), 32'd1);
        check("b2b_instr2", instr, 32'h3333_4444);
        check("b2b_fault2", 32'(fault), 32'd0);
        @(posedge clk); #2;
        check("b2b_valid_end", 32'(instrValid), 32'd0);

        // memAck in IDLE is ignored and outputs hold.
        memAck = 1'b1; memRdata = 32'h7777_7777;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            if (memReq || instrValid || freezePc) cnt++;
        end
        memAck = 1'b0;
        check("idle_ignore_ack", 32'(cnt), 32'd0);
        check("idle_instr_hold", instr, 32'h3333_4444);

        // Reset on the second REQ cycle, then a stray ack after release.
        pcAddr  = 32'h0000_0200;
        fetchEn = 1'b1;
        @(posedge clk); #1;
        fetchEn = 1'b0;
        @(posedge clk); #1;
        check("rstmid_req_before", 32'(memReq), 32'd1);
        nrst = 1'b0;
        #1;
        check("rstmid_memReq", 32'(memReq), 32'd0);
        check("rstmid_memAddr", memAddr, 32'd0);
        check("rstmid_instr", instr, NOP);
        check("rstmid_fault", 32'(fault), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        memAck = 1'b1; memRdata = 32'h9999_9999;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            memAck = 1'b0;
            #1;
            if (memReq || instrValid) cnt++;
        end
        check("rstmid_ack_ignored", 32'(cnt), 32'd0);
        check("rstmid_instr_after", instr, NOP);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            else if (a[1:0] == 2'b00) a[1:0] = 2'b10;
            rv = predict(a, $urandom_range(1, TB_T + 2), $urandom);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
